hs_arbiter: RTL
===============

HS_ARBITER -- requirements
Module: hs_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one handshake source port; legal range 2..16.
REQ-002 Parameter WIDTH, default 7: payload width per requester.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: WAIT-state watchdog limit; used only with HS_ARB_TIMEOUT_EN.
REQ-004 Derived constant ID_W = $clog2(N_REQ); the handshake instance is built with width WIDTH+ID_W.
REQ-005 Port clk, input, 1: single clock; the arbiter runs in the handshake source clock domain.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, N_REQ: per-requester transfer request, level.
REQ-008 Port data, input, N_REQ*WIDTH: flattened payloads; requester i owns bits [i*WIDTH +: WIDTH].
REQ-009 Port done, output, N_REQ: one-cycle pulse to requester i when its word has been loaded by the handshake.
REQ-010 Port busy, output, 1: high in LOAD and WAIT.
REQ-011 Port hs_new_data, output, 1: drives the handshake new-data flag.
REQ-012 Port hs_data, output, WIDTH+ID_W: {winner id, payload}; the id occupies the MSBs.
REQ-013 Port hs_send, input, 1: handshake pulse meaning the buffered word has been taken.
REQ-014 Port timeout_err, output, 1: sticky watchdog error flag.

Function
REQ-015 The arbiter SHALL be a three-state FSM: IDLE, LOAD, WAIT.
REQ-016 In IDLE with any req bit high, it SHALL pick a winner round-robin, searching from last_grant+1 modulo N_REQ, and move to LOAD on the next edge.
REQ-017 On that edge it SHALL register the winner's payload and id into hs_data and set last_grant to the winner.
REQ-018 hs_data SHALL hold stable from LOAD until the WAIT exit edge.
REQ-019 In LOAD, hs_new_data SHALL be 1 for exactly that one cycle; hs_send SHALL be ignored in LOAD; the next state SHALL be WAIT.
REQ-020 In WAIT with hs_send=1, it SHALL pulse done[winner] for one cycle on the next edge and return to IDLE; hs_new_data SHALL be 0 in WAIT.
REQ-021 hs_send in IDLE (including the post-reset start pulse) SHALL have no effect.
REQ-022 req SHALL be sampled only in IDLE; dropping req after the grant SHALL NOT abort the transfer.
REQ-023 Requester data SHALL be captured only on the grant edge; later changes SHALL be ignored.
REQ-024 Latency: req high in IDLE at cycle t gives hs_new_data at t+1; done fires one cycle after the hs_send cycle.
REQ-025 Arbitration SHALL resume in the IDLE cycle after done, so there is at most one transfer in flight.
REQ-026 With a single continuously active requester, that requester SHALL be re-granted on every IDLE cycle.
REQ-027 Pointer wrap-around: with last_grant = N_REQ-1, the search SHALL start at 0.

Reset
REQ-028 Reset SHALL force state IDLE, last_grant = N_REQ-1 (so requester 0 wins first), and hs_data = 0.
REQ-029 Reset SHALL force done = 0, busy = 0, hs_new_data = 0, timeout_err = 0, and the watchdog count = 0.
REQ-030 Reset asserted in LOAD or WAIT SHALL abandon the transfer with no done pulse.

Configuration
REQ-031 With HS_ARB_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-032 On the counter reaching TIMEOUT_CYCLES without hs_send, the block SHALL set timeout_err sticky, return to IDLE with no done pulse, and keep last_grant unchanged.
REQ-033 hs_send and timeout in the same cycle SHALL count as success.
REQ-034 Without HS_ARB_TIMEOUT_EN, timeout_err SHALL be tied 0, no counter logic SHALL exist, and WAIT SHALL last indefinitely.

Structure
REQ-035 Package hs_arb_pkg SHALL hold the state enum (IDLE, LOAD, WAIT) and the default parameter constants.
REQ-036 Sub-module rr_pick SHALL be a combinational round-robin selector: inputs req and last_grant; outputs winner and any.

Verification
REQ-037 Reset, req=4'b0001, data0=7'h2A, hs_send 3 cycles after hs_new_data -> hs_data={2'd0,7'h2A}, one hs_new_data pulse, done=4'b0001 one cycle after hs_send.
REQ-038 req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-039 last_grant=1, req=4'b0011 -> requester 0 is granted (wrap-around).
REQ-040 hs_send held high from reset through the first LOAD -> no transfer completes until hs_send is seen in WAIT.
REQ-041 With HS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, hs_send never pulsed -> timeout_err=1 at WAIT cycle 16, state IDLE, no done pulse; reset clears timeout_err.
REQ-042 Reset asserted in WAIT -> next cycle IDLE, done=0, busy=0, hs_new_data=0.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// rtl/hs_arb_pkg.sv - shared state encoding and default parameters for hs_arbiter
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int N_REQ_DEF          = 4;
  localparam int WIDTH_DEF          = 7;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/hs_arbiter_rr_pick.sv
// rtl/hs_arbiter_rr_pick.sv - combinational round-robin selector starting after last_grant
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  int   idx;
  logic found;

  // Walk last_grant+1 .. last_grant+N_REQ so the previous winner is checked last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/hs_arbiter.sv
// rtl/hs_arbiter.sv - round-robin arbiter feeding one handshake source port
// Optional WAIT watchdog enabled by defining HS_ARB_TIMEOUT_EN.
module hs_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int N_REQ          = N_REQ_DEF,
  parameter  int WIDTH          = WIDTH_DEF,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int ID_W           = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic                  hs_new_data,
  output logic [WIDTH+ID_W-1:0] hs_data,
  input  logic                  hs_send,
  output logic                  timeout_err
);

  arb_state_t      state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] grant_id;
  logic            any_req;
  logic            timeout_hit;

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("hs_arbiter: illegal parameter value");
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any_req)
  );

  // The in-flight winner id lives in the MSBs of the held word.
  assign grant_id    = hs_data[WIDTH +: ID_W];
  assign busy        = (state != IDLE);
  assign hs_new_data = (state == LOAD);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (hs_send || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      hs_data    <= '0;
      done       <= '0;
    end else begin
      state <= state_nxt;
      done  <= '0;
      if (state == IDLE && any_req) begin
        hs_data    <= {winner, data[winner*WIDTH +: WIDTH]};
        last_grant <= winner;
      end
      if (state == WAIT && hs_send) begin
        done[grant_id] <= 1'b1;
      end
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // hs_send wins over a coincident expiry.
  assign timeout_hit = (state == WAIT) && !hs_send &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == LOAD) begin
        wd_cnt <= '0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
